// File: rtl/hood_mode_ctrl.sv
// Range-hood operating-mode scheduler: standby, fan levels 1-3 and self-clean,
// driven by menu/mode buttons and gated by power_on. Owns the mode countdown.
//
// state      | meaning
// -----------+-------------------------------------------------
// S_OFF      | machine off, everything cleared
// S_STANDBY  | powered, fan idle, waiting for menu
// S_MENU_SEL | menu open, waiting for a mode/clean selection
// S_L1       | fan level 1
// S_L2       | fan level 2
// S_L3       | fan level 3, time-limited, once per power cycle
// S_EXIT_CD  | level-2 run-down after leaving level 3 via menu
// S_CLEAN    | timed self-clean, buttons locked out
module hood_mode_ctrl #(
  parameter int unsigned L3_SECS    = 60,
  parameter int unsigned EXIT_SECS  = 60,
  parameter int unsigned CLEAN_SECS = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_power_on,
  input  logic       i_sec_tick,
  input  logic       i_menu_btn,
  input  logic       i_mode1_btn,
  input  logic       i_mode2_btn,
  input  logic       i_mode3_btn,
  input  logic       i_clean_btn,
  output logic [2:0] o_mode_state,
  output logic [7:0] o_countdown,
  output logic       o_l3_used,
  output logic       o_clean_done
);

  typedef enum logic [2:0] {
    S_OFF, S_STANDBY, S_MENU_SEL, S_L1, S_L2, S_L3, S_EXIT_CD, S_CLEAN
  } state_t;

  localparam logic [7:0] L3_LOAD    = 8'(L3_SECS);
  localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_SECS);
  localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_SECS);

  state_t     r_state;
  logic [7:0] r_countdown;
  logic       r_l3_used;
  logic       r_clean_done;
  logic [4:0] r_btn_q;

  state_t     w_state_nxt;
  logic [7:0] w_countdown_nxt;
  logic       w_l3_used_nxt;
  logic       w_clean_done_nxt;
  logic [4:0] w_btn;
  logic [4:0] w_edge;
  logic       w_menu_e, w_mode1_e, w_mode2_e, w_mode3_e, w_clean_e;
  logic       w_timed;
  logic       w_expire;
  logic [7:0] w_load;

  // Bit order is also the priority order: menu highest, clean lowest.
  assign w_btn     = {i_menu_btn, i_mode1_btn, i_mode2_btn, i_mode3_btn, i_clean_btn};
  assign w_edge    = w_btn & ~r_btn_q;
  assign w_menu_e  = w_edge[4];
  assign w_mode1_e = w_edge[3];
  assign w_mode2_e = w_edge[2];
  assign w_mode3_e = w_edge[1];
  assign w_clean_e = w_edge[0];

  assign w_timed  = (r_state == S_L3) || (r_state == S_EXIT_CD) || (r_state == S_CLEAN);
  assign w_expire = w_timed && i_sec_tick && (r_countdown == 8'd1);

  // State, timer, flags and button history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_OFF;
      r_countdown  <= 8'd0;
      r_l3_used    <= 1'b0;
      r_clean_done <= 1'b0;
      r_btn_q      <= 5'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_countdown  <= w_countdown_nxt;
      r_l3_used    <= w_l3_used_nxt;
      r_clean_done <= w_clean_done_nxt;
      r_btn_q      <= w_btn;
    end
  end

  // Next state: power loss, then timer expiry, then the highest valid button edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_l3_used_nxt    = r_l3_used;
    w_clean_done_nxt = 1'b0;
    if (!i_power_on) begin
      w_state_nxt   = S_OFF;
      w_l3_used_nxt = 1'b0;
    end else if (w_expire) begin
      case (r_state)
        S_L3:    w_state_nxt = S_L2;
        S_CLEAN: begin
          w_state_nxt      = S_STANDBY;
          w_clean_done_nxt = 1'b1;
        end
        default: w_state_nxt = S_STANDBY;
      endcase
    end else begin
      case (r_state)
        S_OFF:     w_state_nxt = S_STANDBY;
        S_STANDBY: if (w_menu_e) w_state_nxt = S_MENU_SEL;
        S_MENU_SEL: begin
          // A blocked mode3 edge is not valid, so a lower-priority clean edge may still act.
          if (w_menu_e)                      w_state_nxt = S_STANDBY;
          else if (w_mode1_e)                w_state_nxt = S_L1;
          else if (w_mode2_e)                w_state_nxt = S_L2;
          else if (w_mode3_e && !r_l3_used) begin
            w_state_nxt   = S_L3;
            w_l3_used_nxt = 1'b1;
          end
          else if (w_clean_e)                w_state_nxt = S_CLEAN;
        end
        S_L1: begin
          if (w_menu_e)       w_state_nxt = S_STANDBY;
          else if (w_mode2_e) w_state_nxt = S_L2;
        end
        S_L2: begin
          if (w_menu_e)       w_state_nxt = S_STANDBY;
          else if (w_mode1_e) w_state_nxt = S_L1;
        end
        S_L3:    if (w_menu_e) w_state_nxt = S_EXIT_CD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Countdown: load on entry to a timed state, tick down while in it, zero elsewhere.
  always_comb begin
    w_load          = 8'd0;
    w_countdown_nxt = 8'd0;
    case (w_state_nxt)
      S_L3:      w_load = L3_LOAD;
      S_EXIT_CD: w_load = EXIT_LOAD;
      S_CLEAN:   w_load = CLEAN_LOAD;
      default:   w_load = 8'd0;
    endcase
    if (w_load == 8'd0)
      w_countdown_nxt = 8'd0;
    else if (w_state_nxt != r_state)
      w_countdown_nxt = w_load;
    else if (i_sec_tick && (r_countdown != 8'd0))
      w_countdown_nxt = r_countdown - 8'd1;
    else
      w_countdown_nxt = r_countdown;
  end

  // Mode code seen by the display path; the run-down shows as level 2.
  always_comb begin
    o_mode_state = 3'd0;
    case (r_state)
      S_L1:      o_mode_state = 3'd1;
      S_L2:      o_mode_state = 3'd2;
      S_L3:      o_mode_state = 3'd3;
      S_EXIT_CD: o_mode_state = 3'd2;
      S_CLEAN:   o_mode_state = 3'd4;
      default:   o_mode_state = 3'd0;
    endcase
  end

  assign o_countdown  = r_countdown;
  assign o_l3_used    = r_l3_used;
  assign o_clean_done = r_clean_done;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with a scoreboard queue of expected outputs.
module tb_hood_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic       sec_tick;
  logic       menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn;
  logic [2:0] mode_state;
  logic [7:0] countdown;
  logic       l3_used;
  logic       clean_done;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] MENU = 5'b10000;
  localparam logic [4:0] M1   = 5'b01000;
  localparam logic [4:0] M2   = 5'b00100;
  localparam logic [4:0] M3   = 5'b00010;
  localparam logic [4:0] CL   = 5'b00001;

  typedef struct {
    string      tag;
    logic [2:0] mode;
    logic [7:0] cd;
    logic       l3;
    logic       done;
  } exp_t;

  exp_t sb_q[$];

  hood_mode_ctrl #(.L3_SECS(3), .EXIT_SECS(2), .CLEAN_SECS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_power_on   (power_on),
    .i_sec_tick   (sec_tick),
    .i_menu_btn   (menu_btn),
    .i_mode1_btn  (mode1_btn),
    .i_mode2_btn  (mode2_btn),
    .i_mode3_btn  (mode3_btn),
    .i_clean_btn  (clean_btn),
    .o_mode_state (mode_state),
    .o_countdown  (countdown),
    .o_l3_used    (l3_used),
    .o_clean_done (clean_done)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [2:0] m, input logic [7:0] c,
                      input logic l, input logic d);
    exp_t e;
    e.tag = tag; e.mode = m; e.cd = c; e.l3 = l; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (mode_state === e.mode) else begin
      failures++;
      $error("FAIL %s mode_state got=%0d exp=%0d", e.tag, mode_state, e.mode);
    end
    checks++;
    assert (countdown === e.cd) else begin
      failures++;
      $error("FAIL %s countdown got=%0d exp=%0d", e.tag, countdown, e.cd);
    end
    checks++;
    assert (l3_used === e.l3) else begin
      failures++;
      $error("FAIL %s l3_used got=%0d exp=%0d", e.tag, l3_used, e.l3);
    end
    checks++;
    assert (clean_done === e.done) else begin
      failures++;
      $error("FAIL %s clean_done got=%0d exp=%0d", e.tag, clean_done, e.done);
    end
  endtask

  // Drive one cycle of stimulus, record what must appear after the edge, then compare.
  task automatic cyc(input logic [4:0] btn, input logic tick, input logic [2:0] m,
                     input logic [7:0] c, input logic l, input logic d, input string tag);
    {menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn} = btn;
    sec_tick = tick;
    push(tag, m, c, l, d);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; power_on = 1'b0; sec_tick = 1'b0;
    {menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn} = NONE;
    #12;
    push("reset", 3'd0, 8'd0, 1'b0, 1'b0);
    check_pop();
    reset = 1'b1; power_on = 1'b1;

    cyc(NONE, 0, 0, 0, 0, 0, "pwr_up");
    // menu path
    cyc(MENU, 0, 0, 0, 0, 0, "t1_menu");
    cyc(M2,   0, 2, 0, 0, 0, "t1_mode2");
    cyc(M1,   0, 1, 0, 0, 0, "t1_mode1");
    cyc(MENU, 0, 0, 0, 0, 0, "t1_menu_exit");
    cyc(NONE, 0, 0, 0, 0, 0, "t1_idle");
    // level 3 time limit
    cyc(MENU, 0, 0, 0, 0, 0, "t2_menu");
    cyc(M3,   0, 3, 3, 1, 0, "t2_l3");
    cyc(NONE, 1, 3, 2, 1, 0, "t2_tick1");
    cyc(NONE, 1, 3, 1, 1, 0, "t2_tick2");
    cyc(NONE, 1, 2, 0, 1, 0, "t2_expire");
    cyc(NONE, 0, 2, 0, 1, 0, "t2_l2_hold");
    cyc(MENU, 0, 0, 0, 1, 0, "t2_standby");
    cyc(NONE, 0, 0, 0, 1, 0, "t2_idle");
    cyc(MENU, 0, 0, 0, 1, 0, "t2_menu2");
    cyc(M3,   0, 0, 0, 1, 0, "t2_l3_blocked");
    cyc(M1,   0, 1, 0, 1, 0, "t2_still_menu");
    cyc(MENU, 0, 0, 0, 1, 0, "t2_back");
    cyc(NONE, 0, 0, 0, 1, 0, "t2_idle2");
    // self-clean with buttons locked out
    cyc(MENU, 0, 0, 0, 1, 0, "t4_menu");
    cyc(CL,   0, 4, 4, 1, 0, "t4_clean");
    cyc(M1,   0, 4, 4, 1, 0, "t4_ign_m1");
    cyc(MENU, 0, 4, 4, 1, 0, "t4_ign_menu");
    cyc(M3,   0, 4, 4, 1, 0, "t4_ign_m3");
    cyc(CL,   0, 4, 4, 1, 0, "t4_ign_clean");
    cyc(NONE, 1, 4, 3, 1, 0, "t4_tick1");
    cyc(NONE, 1, 4, 2, 1, 0, "t4_tick2");
    cyc(NONE, 1, 4, 1, 1, 0, "t4_tick3");
    cyc(NONE, 1, 0, 0, 1, 1, "t4_done");
    cyc(NONE, 0, 0, 0, 1, 0, "t4_done_end");
    // simultaneous and held buttons
    cyc(MENU,    0, 0, 0, 1, 0, "t5_menu");
    cyc(M1 | M2, 0, 1, 0, 1, 0, "t5_simul");
    cyc(NONE,    0, 1, 0, 1, 0, "t5_release");
    for (int i = 0; i < 100; i++) cyc(M2, 0, 2, 0, 1, 0, "t5_hold_m2");
    for (int i = 0; i < 10; i++)  cyc(MENU, 0, 0, 0, 1, 0, "t5_hold_menu");
    cyc(NONE, 0, 0, 0, 1, 0, "t5_release2");
    cyc(M1,   0, 0, 0, 1, 0, "t5_menu_once");
    // tick on entry ignored, power loss on the expiring tick
    cyc(MENU, 0, 0, 0, 1, 0, "t6_menu");
    cyc(CL,   1, 4, 4, 1, 0, "t6_tick_on_entry");
    cyc(NONE, 1, 4, 3, 1, 0, "t6_tick1");
    cyc(NONE, 1, 4, 2, 1, 0, "t6_tick2");
    cyc(NONE, 1, 4, 1, 1, 0, "t6_tick3");
    power_on = 1'b0;
    cyc(NONE, 1, 0, 0, 0, 0, "t6_loss_on_expiry");
    cyc(NONE, 0, 0, 0, 0, 0, "t6_off");
    power_on = 1'b1;
    cyc(NONE, 0, 0, 0, 0, 0, "t6_restore");
    // level 3 allowed again, exit run-down
    cyc(MENU,        0, 0, 0, 0, 0, "t3_menu");
    cyc(M3,          0, 3, 3, 1, 0, "t3_l3_again");
    cyc(NONE,        1, 3, 2, 1, 0, "t3_tick");
    cyc(MENU,        0, 2, 2, 1, 0, "t3_exit");
    cyc(NONE,        1, 2, 1, 1, 0, "t3_tick1");
    cyc(NONE,        0, 2, 1, 1, 0, "t3_hold");
    cyc(M1,          0, 2, 1, 1, 0, "t3_ign_m1");
    cyc(MENU,        1, 0, 0, 1, 0, "t3_expire");
    cyc(NONE,        0, 0, 0, 1, 0, "t3_standby");
    // asynchronous reset in the middle of a clean run
    cyc(MENU, 0, 0, 0, 1, 0, "r_menu");
    cyc(CL,   0, 4, 4, 1, 0, "r_clean");
    cyc(NONE, 1, 4, 3, 1, 0, "r_tick");
    sec_tick = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    push("rst_async", 3'd0, 8'd0, 1'b0, 1'b0);
    check_pop();
    #2;
    reset = 1'b1;
    cyc(NONE, 0, 0, 0, 0, 0, "rst_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
